// File: rtl/cmd_link_pkg.sv
// Shared definitions for the command link initiator.
//   state_t  : initiator FSM states
//   status_t : response status codes reported on rsp_status
//   RW_BIT   : bit position of the read/write flag in the command byte
//   ID_W     : register id width
//   SIZE_W   : payload size field width
package cmd_link_pkg;

    localparam int RW_BIT = 7;
    localparam int ID_W   = 7;
    localparam int SIZE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_CTS,
        ST_SEND_CMD,
        ST_SEND_SIZE,
        ST_SEND_DATA,
        ST_RECV_DATA,
        ST_FINISH
    } state_t;

    typedef enum logic [1:0] {
        STATUS_OK       = 2'd0,
        STATUS_BAD_SIZE = 2'd1,
        STATUS_TIMEOUT  = 2'd2,
        STATUS_RX_ERROR = 2'd3
    } status_t;

endpackage

// File: rtl/cmd_watchdog.sv
// Wait-phase watchdog for the command initiator.
//   clk     : system clock
//   reset   : synchronous, active-high
//   clear   : restart the count from zero (state entry / byte progress)
//   enable  : count only while the initiator is in a wait phase
//   expired : high during the TIMEOUT_CYCLES-th cycle since the last clear
module cmd_watchdog #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    // Count saturates at LAST so a stalled consumer cannot wrap it back.
    always_ff @(posedge clk) begin
        if (reset || clear || !enable) begin
            count <= '0;
        end else if (count != LAST) begin
            count <= count + CNT_W'(1);
        end
    end

    // Flag in the last allowed cycle so the FSM is in FINISH exactly
    // TIMEOUT_CYCLES cycles after entering the wait phase.
    assign expired = enable && (count == LAST);

endmodule

// File: rtl/cmd_initiator.sv
// Command initiator: accepts one host command, sends it over a UART link
// ({rw,id}, size, then payload for writes), collects the payload for reads,
// and returns one response pulse with status and read data.
//   clk, reset                     : clock, synchronous active-high reset
//   req_valid/req_ready            : host command handshake
//   req_rw, req_id, req_size,
//   req_wdata                      : command fields (byte k = bits [8k+7:8k])
//   rsp_valid, rsp_rdata, rsp_status : one-cycle response, fields held after
//   tx_write, tx_byte, tx_done     : UART transmitter interface
//   rx_byte, rx_done, rx_error     : UART receiver interface
//   uart_rts (out), uart_cts (in)  : active-low flow control
module cmd_initiator
    import cmd_link_pkg::*;
#(
    parameter int MAX_PAYLOAD_BYTES = 8,
    parameter int TIMEOUT_CYCLES    = 50000
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic                           req_rw,
    input  logic [ID_W-1:0]                req_id,
    input  logic [SIZE_W-1:0]              req_size,
    input  logic [8*MAX_PAYLOAD_BYTES-1:0] req_wdata,
    output logic                           rsp_valid,
    output logic [8*MAX_PAYLOAD_BYTES-1:0] rsp_rdata,
    output logic [1:0]                     rsp_status,
    output logic                           tx_write,
    output logic [7:0]                     tx_byte,
    input  logic                           tx_done,
    input  logic [7:0]                     rx_byte,
    input  logic                           rx_done,
    input  logic                           rx_error,
    output logic                           uart_rts,
    input  logic                           uart_cts
);

    localparam int IDX_W = $clog2(MAX_PAYLOAD_BYTES) + 1;
    localparam int PAY_W = 8 * MAX_PAYLOAD_BYTES;
    localparam logic [SIZE_W-1:0] MAX_SIZE = SIZE_W'(MAX_PAYLOAD_BYTES);

    state_t             state, state_d;
    logic               rw_q;
    logic [ID_W-1:0]    id_q;
    logic [SIZE_W-1:0]  size_q;
    logic [PAY_W-1:0]   wdata_q;
    logic [PAY_W-1:0]   rdata_q, rdata_n;
    logic [IDX_W-1:0]   idx;
    logic               sent;        // current byte already handed to the transmitter

    logic               accept, size_bad, idx_last;
    logic               send_now, tx_adv, rx_store, finish;
    logic [7:0]         send_byte;
    status_t            fin_status;
    logic               wd_clear, wd_enable, wd_expired;

    assign req_ready = (state == ST_IDLE) && uart_cts;
    assign size_bad  = (req_size == '0) || (req_size > MAX_SIZE);
    assign idx_last  = (SIZE_W'(idx) == size_q - SIZE_W'(1));

    always_comb begin
        state_d    = state;
        accept     = 1'b0;
        send_now   = 1'b0;
        send_byte  = '0;
        tx_adv     = 1'b0;
        rx_store   = 1'b0;
        finish     = 1'b0;
        fin_status = STATUS_OK;
        case (state)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    accept = 1'b1;
                    if (size_bad) begin
                        state_d    = ST_FINISH;
                        finish     = 1'b1;
                        fin_status = STATUS_BAD_SIZE;
                    end else begin
                        state_d = ST_WAIT_CTS;
                    end
                end
            end
            ST_WAIT_CTS: begin
                if (!uart_cts) begin
                    state_d = ST_SEND_CMD;
                end else if (wd_expired) begin
                    state_d    = ST_FINISH;
                    finish     = 1'b1;
                    fin_status = STATUS_TIMEOUT;
                end
            end
            ST_SEND_CMD: begin
                if (!sent) begin
                    send_now             = 1'b1;
                    send_byte[RW_BIT]    = rw_q;
                    send_byte[ID_W-1:0]  = id_q;
                end else if (tx_done) begin
                    tx_adv  = 1'b1;
                    state_d = ST_SEND_SIZE;
                end else if (wd_expired) begin
                    state_d    = ST_FINISH;
                    finish     = 1'b1;
                    fin_status = STATUS_TIMEOUT;
                end
            end
            ST_SEND_SIZE: begin
                if (!sent) begin
                    send_now  = 1'b1;
                    send_byte = size_q;
                end else if (tx_done) begin
                    tx_adv  = 1'b1;
                    state_d = rw_q ? ST_SEND_DATA : ST_RECV_DATA;
                end else if (wd_expired) begin
                    state_d    = ST_FINISH;
                    finish     = 1'b1;
                    fin_status = STATUS_TIMEOUT;
                end
            end
            ST_SEND_DATA: begin
                if (!sent) begin
                    send_now  = 1'b1;
                    send_byte = wdata_q[int'(idx)*8 +: 8];
                end else if (tx_done) begin
                    tx_adv = 1'b1;
                    if (idx_last) begin
                        state_d = ST_FINISH;
                        finish  = 1'b1;
                    end
                end else if (wd_expired) begin
                    state_d    = ST_FINISH;
                    finish     = 1'b1;
                    fin_status = STATUS_TIMEOUT;
                end
            end
            ST_RECV_DATA: begin
                // A fault on the byte wins over a simultaneous rx_done.
                if (rx_error) begin
                    state_d    = ST_FINISH;
                    finish     = 1'b1;
                    fin_status = STATUS_RX_ERROR;
                end else if (rx_done) begin
                    rx_store = 1'b1;
                    if (idx_last) begin
                        state_d = ST_FINISH;
                        finish  = 1'b1;
                    end
                end else if (wd_expired) begin
                    state_d    = ST_FINISH;
                    finish     = 1'b1;
                    fin_status = STATUS_TIMEOUT;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Capture register as it will look after this cycle; the response
    // snapshot uses it so the final received byte is included.
    always_comb begin
        rdata_n = rdata_q;
        if (accept) begin
            rdata_n = '0;
        end else if (rx_store) begin
            rdata_n[int'(idx)*8 +: 8] = rx_byte;
        end
    end

    assign wd_enable = (state == ST_WAIT_CTS)  || (state == ST_SEND_CMD) ||
                       (state == ST_SEND_SIZE) || (state == ST_SEND_DATA) ||
                       (state == ST_RECV_DATA);
    assign wd_clear  = (state_d != state) || tx_done || rx_done;

    cmd_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            sent       <= 1'b0;
            idx        <= '0;
            rdata_q    <= '0;
            uart_rts   <= 1'b1;
            tx_write   <= 1'b0;
            tx_byte    <= '0;
            rsp_valid  <= 1'b0;
            rsp_status <= '0;
            rsp_rdata  <= '0;
        end else begin
            state     <= state_d;
            tx_write  <= send_now;
            rsp_valid <= finish;
            rdata_q   <= rdata_n;
            if (send_now) begin
                tx_byte <= send_byte;
            end
            if ((state_d != state) || tx_adv) begin
                sent <= 1'b0;
            end else if (send_now) begin
                sent <= 1'b1;
            end
            if (accept) begin
                idx <= '0;
            end else if (rx_store || (tx_adv && (state == ST_SEND_DATA))) begin
                idx <= idx + IDX_W'(1);
            end
            if (accept && !size_bad) begin
                uart_rts <= 1'b0;
            end else if (finish) begin
                uart_rts <= 1'b1;
            end
            if (finish) begin
                rsp_status <= fin_status;
                rsp_rdata  <= rdata_n;
            end
        end
    end

    // Command fields only matter after an accept, so they carry no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            rw_q    <= req_rw;
            id_q    <= req_id;
            size_q  <= req_size;
            wdata_q <= req_wdata;
        end
    end

endmodule

// File: tb/tb_cmd_initiator.sv
module tb_cmd_initiator;

    localparam int MAXB = 8;
    localparam int TMO  = 100;
    localparam int HOLD = 1000000;   // cts delay meaning "responder never answers"
    localparam int NOERR = 99;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_rw;
    logic [6:0]  req_id;
    logic [7:0]  req_size;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic [1:0]  rsp_status;
    logic        tx_write, tx_done;
    logic [7:0]  tx_byte, rx_byte;
    logic        rx_done, rx_error, uart_rts, uart_cts;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cmd_initiator #(
        .MAX_PAYLOAD_BYTES (MAXB),
        .TIMEOUT_CYCLES    (TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_rw     (req_rw),
        .req_id     (req_id),
        .req_size   (req_size),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_status (rsp_status),
        .tx_write   (tx_write),
        .tx_byte    (tx_byte),
        .tx_done    (tx_done),
        .rx_byte    (rx_byte),
        .rx_done    (rx_done),
        .rx_error   (rx_error),
        .uart_rts   (uart_rts),
        .uart_cts   (uart_cts)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One host command against a behavioural responder. The expected byte
    // stream, status and read data are derived from the command alone.
    task automatic run_cmd(input bit rw, input logic [6:0] id, input logic [7:0] size,
                           input logic [63:0] wd, input logic [63:0] rxd,
                           input int cts_dly, input int err_at, input int rst_at);
        logic [7:0]  txq[$];
        logic [7:0]  expq[$];
        logic [63:0] exp_rd = '0;
        logic [1:0]  exp_st;
        bit bad  = (size == 0) || (size > MAXB);
        bit hold = (cts_dly >= HOLD);
        bit accepted = 0, done = 0, rx_on = 0, rx_stop = 0, outstanding = 0;
        int t = 0, n_rsp = 0, rsp_at = -1, rts_low_at = -1, rts_low_cnt = 0;
        int tx_cd = 0, rx_cd = 0, rx_idx = 0, rst_t = -1;

        if (!bad && rst_at == 0) begin
            expq.push_back({rw, id});
            expq.push_back(size);
            if (rw && !hold)
                for (int k = 0; k < size; k++) expq.push_back(wd[k*8 +: 8]);
        end
        if (hold) expq.delete();
        exp_st = bad ? 2'd1 : hold ? 2'd2 : (!rw && err_at < size) ? 2'd3 : 2'd0;
        if (!bad && !rw && !hold)
            for (int k = 0; k < size && k < err_at; k++) exp_rd[k*8 +: 8] = rxd[k*8 +: 8];

        req_rw = rw; req_id = id; req_size = size; req_wdata = wd; req_valid = 1'b1;
        #1;
        if (req_ready) accepted = 1;

        while (!done && t < 3000) begin
            @(posedge clk); #1; t++;
            tx_done = 1'b0; rx_done = 1'b0; rx_error = 1'b0;
            if (accepted) req_valid = 1'b0;

            if (rst_t >= 0) begin
                if (t == rst_t + 1) begin
                    reset = 1'b0;
                    chk("rst_rts", uart_rts, 1);
                    chk("rst_rsp_valid", rsp_valid, 0);
                    chk("rst_tx_write", tx_write, 0);
                    chk("rst_status", rsp_status, 0);
                end
                if (t == rst_t + 6) done = 1;
            end

            if (uart_rts == 1'b0) begin
                if (rts_low_at < 0) rts_low_at = t;
                rts_low_cnt++;
                if (rts_low_cnt > cts_dly) uart_cts = 1'b0;
            end else begin
                rts_low_cnt = 0;
                uart_cts = 1'b1;
            end

            if (rx_on && !rx_stop) begin
                rx_cd--;
                if (rx_cd == 0) begin
                    if (rx_idx == err_at) begin
                        rx_error = 1'b1;
                        rx_stop = 1;
                    end else begin
                        rx_done = 1'b1;
                        rx_byte = rxd[rx_idx*8 +: 8];
                        rx_idx++;
                        if (rx_idx == size) rx_stop = 1;
                        else rx_cd = $urandom_range(1, 4);
                    end
                end
            end

            if (tx_write) begin
                chk("tx_spacing", outstanding, 0);
                txq.push_back(tx_byte);
                outstanding = 1;
                tx_cd = $urandom_range(1, 4);
                if (rst_at > 0 && rst_t < 0 && txq.size() == rst_at) begin
                    reset = 1'b1;
                    rst_t = t;
                end
            end else if (outstanding) begin
                tx_cd--;
                if (tx_cd == 0) begin
                    tx_done = 1'b1;
                    outstanding = 0;
                    if (!rw && txq.size() == 2) begin
                        rx_on = 1;
                        rx_cd = $urandom_range(2, 5);
                    end
                end
            end

            if (rsp_valid) begin
                n_rsp++;
                if (n_rsp == 1) begin
                    rsp_at = t;
                    chk("status", rsp_status, exp_st);
                    chk("rdata", rsp_rdata, exp_rd);
                    chk("rts_finish", uart_rts, 1);
                    if (hold) chk("timeout_latency", rsp_at - rts_low_at, TMO);
                end
            end
            if (rsp_at >= 0 && t == rsp_at + 1) begin
                chk("rsp_pulse", rsp_valid, 0);
                chk("rsp_hold", rsp_rdata, exp_rd);
                chk("rts_idle", uart_rts, 1);
            end
            if (rsp_at >= 0 && t == rsp_at + 2) done = 1;

            #1;
            if (req_valid && req_ready) accepted = 1;
        end

        if (!done) chk("cycle_bound", 0, 1);
        chk("rsp_count", n_rsp, (rst_at > 0) ? 0 : 1);
        if (rst_at == 0) begin
            chk("tx_count", txq.size(), expq.size());
            for (int k = 0; k < txq.size() && k < expq.size(); k++)
                chk("tx_byte", txq[k], expq[k]);
        end
        if (bad) chk("rts_never_low", rts_low_at, -1);

        req_valid = 1'b0; tx_done = 1'b0; rx_done = 1'b0; rx_error = 1'b0;
        reset = 1'b0; uart_cts = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_rw = 1'b0; req_id = '0; req_size = '0;
        req_wdata = '0; tx_done = 1'b0; rx_byte = '0; rx_done = 1'b0; rx_error = 1'b0;
        uart_cts = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rts", uart_rts, 1);
        chk("reset_tx_write", tx_write, 0);
        chk("reset_tx_byte", tx_byte, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_status", rsp_status, 0);
        chk("reset_rdata", rsp_rdata, 0);
        reset = 1'b0;
        #1;
        chk("idle_ready", req_ready, 1);
        @(posedge clk); #1;

        // Write id 3, two bytes, responder clears after 5 cycles
        run_cmd(1'b1, 7'h03, 8'd2, 64'hBEEF, 64'h0, 5, NOERR, 0);
        // Read id 1, three bytes
        run_cmd(1'b0, 7'h01, 8'd3, 64'h0, 64'h332211, 2, NOERR, 0);
        // Illegal sizes
        run_cmd(1'b1, 7'h10, 8'd0, 64'h1234, 64'h0, 1, NOERR, 0);
        run_cmd(1'b0, 7'h11, 8'd9, 64'h0, 64'h55, 1, NOERR, 0);
        // Responder never clears cts
        run_cmd(1'b0, 7'h05, 8'd2, 64'h0, 64'hAABB, HOLD, NOERR, 0);
        // Receive fault on the second byte
        run_cmd(1'b0, 7'h22, 8'd4, 64'h0, 64'h44332211, 0, 1, 0);
        // Reset while byte 1 of a write payload is in flight
        run_cmd(1'b1, 7'h33, 8'd4, 64'hD4C3B2A1, 64'h0, 1, NOERR, 4);
        // Full-size transfers
        run_cmd(1'b1, 7'h7F, 8'd8, 64'h0807060504030201, 64'h0, 0, NOERR, 0);
        run_cmd(1'b0, 7'h40, 8'd8, 64'h0, 64'hF1E2D3C4B5A69788, 3, NOERR, 0);

        for (int n = 0; n < 20; n++) begin
            bit          r_rw   = 1'($urandom_range(0, 1));
            logic [7:0]  r_size = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 12)) * 8'(($urandom_range(0,1))) + (($urandom_range(0,1) == 1) ? 8'd9 : 8'd0)
                                                             : 8'($urandom_range(1, MAXB));
            logic [63:0] r_wd   = {$urandom, $urandom};
            logic [63:0] r_rx   = {$urandom, $urandom};
            int          r_err  = NOERR;
            if (!r_rw && r_size >= 1 && r_size <= MAXB && $urandom_range(0, 2) == 0)
                r_err = $urandom_range(0, int'(r_size) - 1);
            run_cmd(r_rw, 7'($urandom), r_size, r_wd, r_rx, $urandom_range(0, 8), r_err, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
